// File: rtl/dma_ch_sched.sv
// DMA channel scheduler: grants one requesting channel at a time, round-robin,
// and splits its descriptor into buffer-sized read/write chunk pairs for the transfer engine.
module dma_ch_sched #(
   parameter int NUM_CH      = 4,
   parameter int BUFFER_SIZE = 4,
   parameter int LEN_W       = 16
) (
   input  logic                           hclk,
   input  logic                           hresetn,
   input  logic [NUM_CH-1:0]              ch_req_i,
   input  logic [NUM_CH*32-1:0]           ch_src_addr_i,
   input  logic [NUM_CH*32-1:0]           ch_dst_addr_i,
   input  logic [NUM_CH*LEN_W-1:0]        ch_len_i,
   input  logic [NUM_CH*2-1:0]            ch_size_i,
   input  logic [NUM_CH-1:0]              ch_src_incr_i,
   input  logic [NUM_CH-1:0]              ch_dst_incr_i,
   output logic [NUM_CH-1:0]              ch_busy_o,
   output logic [NUM_CH-1:0]              ch_done_o,
   output logic [NUM_CH-1:0]              ch_err_o,
   output logic                           eng_valid_o,
   output logic                           eng_mode_o,
   output logic [31:0]                    eng_rd_addr_o,
   output logic [31:0]                    eng_wr_addr_o,
   output logic [$clog2(4*BUFFER_SIZE):0] eng_len_o,
   output logic [1:0]                     eng_size_o,
   output logic                           eng_incr_o,
   output logic                           eng_enable_o,
   output logic                           eng_race_o,
   input  logic                           eng_ready_i,
   input  logic                           eng_last_i,
   input  logic                           eng_last_write_i,
   input  logic                           hresp_i
);

   localparam int CMAX = 4 * BUFFER_SIZE;
   localparam int CL_W = $clog2(CMAX) + 1;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [LEN_W-1:0] CMAX_LEN = LEN_W'(CMAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_WR_ISSUE,
      S_WR_WAIT,
      S_DONE,
      S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   rr_q, rr_next, grant_q;
   logic [CH_W-1:0]   pick_idx, hi_idx, lo_idx;
   logic              pick_found, hi_found;
   logic [31:0]       src_q, dst_q, sel_src, sel_dst;
   logic [LEN_W-1:0]  rem_q, rem_next, sel_len;
   logic [1:0]        size_q, sel_size;
   logic              src_incr_q, dst_incr_q, sel_src_incr, sel_dst_incr;
   logic              misalign, desc_bad, busy_en, last_chunk;
   logic [CL_W-1:0]   chunk;
   logic [NUM_CH-1:0] grant_1h;

   // Round-robin pick: lowest requester at or above rr, else lowest requester overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (ch_req_i[c]) begin
            lo_idx = CH_W'(c);
         end
         if (ch_req_i[c] && (CH_W'(c) >= rr_q)) begin
            hi_found = 1'b1;
            hi_idx   = CH_W'(c);
         end
      end
      pick_found = |ch_req_i;
      pick_idx   = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_src      = '0;
      sel_dst      = '0;
      sel_len      = '0;
      sel_size     = '0;
      sel_src_incr = 1'b0;
      sel_dst_incr = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pick_idx == CH_W'(c)) begin
            sel_src      = ch_src_addr_i[c*32 +: 32];
            sel_dst      = ch_dst_addr_i[c*32 +: 32];
            sel_len      = ch_len_i[c*LEN_W +: LEN_W];
            sel_size     = ch_size_i[c*2 +: 2];
            sel_src_incr = ch_src_incr_i[c];
            sel_dst_incr = ch_dst_incr_i[c];
         end
      end
   end

   // A descriptor must be a whole number of beats of a legal size.
   assign misalign = (sel_size == 2'd3)
                  || ((sel_size == 2'd1) && sel_len[0])
                  || ((sel_size == 2'd2) && (sel_len[1:0] != 2'b00));
   assign desc_bad = (sel_len == '0) || misalign;

   assign chunk      = (rem_q > CMAX_LEN) ? CL_W'(CMAX) : CL_W'(rem_q);
   assign rem_next   = rem_q - LEN_W'(chunk);
   assign last_chunk = (rem_next == '0);
   assign rr_next    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
   assign grant_1h   = NUM_CH'(1) << grant_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rr_q       <= '0;
         grant_q    <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         size_q     <= '0;
         src_incr_q <= 1'b0;
         dst_incr_q <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && pick_found) begin
            grant_q    <= pick_idx;
            src_q      <= sel_src;
            dst_q      <= sel_dst;
            rem_q      <= sel_len;
            size_q     <= sel_size;
            src_incr_q <= sel_src_incr;
            dst_incr_q <= sel_dst_incr;
         end else if ((state_q == S_WR_WAIT) && eng_last_write_i && !hresp_i) begin
            if (src_incr_q) begin
               src_q <= src_q + 32'(chunk);
            end
            if (dst_incr_q) begin
               dst_q <= dst_q + 32'(chunk);
            end
            rem_q <= rem_next;
         end
         if ((state_q == S_DONE) || (state_q == S_FAIL)) begin
            rr_q <= rr_next;
         end
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      eng_valid_o  = 1'b0;
      eng_mode_o   = 1'b0;
      eng_incr_o   = 1'b0;
      eng_enable_o = 1'b1;
      busy_en      = 1'b0;
      ch_done_o    = '0;
      ch_err_o     = '0;
      case (state_q)
         S_IDLE: begin
            eng_enable_o = 1'b0;
            if (pick_found) begin
               state_d = desc_bad ? S_FAIL : S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            busy_en     = 1'b1;
            eng_incr_o  = src_incr_q;
            eng_valid_o = eng_ready_i;
            if (hresp_i) begin
               state_d = S_FAIL;
            end else if (eng_ready_i) begin
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            busy_en    = 1'b1;
            eng_incr_o = src_incr_q;
            if (hresp_i) begin
               state_d = S_FAIL;
            end else if (eng_last_i) begin
               state_d = S_WR_ISSUE;
            end
         end
         S_WR_ISSUE: begin
            busy_en     = 1'b1;
            eng_mode_o  = 1'b1;
            eng_incr_o  = dst_incr_q;
            eng_valid_o = eng_ready_i;
            if (hresp_i) begin
               state_d = S_FAIL;
            end else if (eng_ready_i) begin
               state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            busy_en    = 1'b1;
            eng_mode_o = 1'b1;
            eng_incr_o = dst_incr_q;
            if (hresp_i) begin
               state_d = S_FAIL;
            end else if (eng_last_write_i) begin
               state_d = last_chunk ? S_DONE : S_RD_ISSUE;
            end
         end
         S_DONE: begin
            ch_done_o = grant_1h;
            state_d   = S_IDLE;
         end
         S_FAIL: begin
            ch_err_o = grant_1h;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ch_busy_o = busy_en ? grant_1h : '0;
   end

   assign eng_rd_addr_o = src_q;
   assign eng_wr_addr_o = dst_q;
   assign eng_len_o     = chunk;
   assign eng_size_o    = size_q;
   assign eng_race_o    = 1'b0;

endmodule

// File: tb/tb_dma_ch_sched.sv
// Bench for dma_ch_sched: acts as the transfer engine and checks every grant,
// chunk and completion against a descriptor-level reference model.
module tb_dma_ch_sched;

   localparam int NUM_CH      = 4;
   localparam int BUFFER_SIZE = 4;
   localparam int LEN_W       = 16;
   localparam int CMAX        = 4 * BUFFER_SIZE;
   localparam int CL_W        = $clog2(CMAX) + 1;

   logic                    hclk = 1'b0;
   logic                    hresetn;
   logic [NUM_CH-1:0]       ch_req_i;
   logic [NUM_CH*32-1:0]    ch_src_addr_i;
   logic [NUM_CH*32-1:0]    ch_dst_addr_i;
   logic [NUM_CH*LEN_W-1:0] ch_len_i;
   logic [NUM_CH*2-1:0]     ch_size_i;
   logic [NUM_CH-1:0]       ch_src_incr_i;
   logic [NUM_CH-1:0]       ch_dst_incr_i;
   logic [NUM_CH-1:0]       ch_busy_o;
   logic [NUM_CH-1:0]       ch_done_o;
   logic [NUM_CH-1:0]       ch_err_o;
   logic                    eng_valid_o;
   logic                    eng_mode_o;
   logic [31:0]             eng_rd_addr_o;
   logic [31:0]             eng_wr_addr_o;
   logic [CL_W-1:0]         eng_len_o;
   logic [1:0]              eng_size_o;
   logic                    eng_incr_o;
   logic                    eng_enable_o;
   logic                    eng_race_o;
   logic                    eng_ready_i;
   logic                    eng_last_i;
   logic                    eng_last_write_i;
   logic                    hresp_i;

   dma_ch_sched #(
      .NUM_CH      (NUM_CH),
      .BUFFER_SIZE (BUFFER_SIZE),
      .LEN_W       (LEN_W)
   ) dut (
      .hclk             (hclk),
      .hresetn          (hresetn),
      .ch_req_i         (ch_req_i),
      .ch_src_addr_i    (ch_src_addr_i),
      .ch_dst_addr_i    (ch_dst_addr_i),
      .ch_len_i         (ch_len_i),
      .ch_size_i        (ch_size_i),
      .ch_src_incr_i    (ch_src_incr_i),
      .ch_dst_incr_i    (ch_dst_incr_i),
      .ch_busy_o        (ch_busy_o),
      .ch_done_o        (ch_done_o),
      .ch_err_o         (ch_err_o),
      .eng_valid_o      (eng_valid_o),
      .eng_mode_o       (eng_mode_o),
      .eng_rd_addr_o    (eng_rd_addr_o),
      .eng_wr_addr_o    (eng_wr_addr_o),
      .eng_len_o        (eng_len_o),
      .eng_size_o       (eng_size_o),
      .eng_incr_o       (eng_incr_o),
      .eng_enable_o     (eng_enable_o),
      .eng_race_o       (eng_race_o),
      .eng_ready_i      (eng_ready_i),
      .eng_last_i       (eng_last_i),
      .eng_last_write_i (eng_last_write_i),
      .hresp_i          (hresp_i)
   );

   always #5 hclk = ~hclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference view of each channel's descriptor and of the round-robin pointer.
   logic [31:0] d_src  [NUM_CH];
   logic [31:0] d_dst  [NUM_CH];
   int          d_len  [NUM_CH];
   int          d_size [NUM_CH];
   bit          d_si   [NUM_CH];
   bit          d_di   [NUM_CH];
   int          rr_model;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] onehot(input int ch);
      return 32'(1) << ch;
   endfunction

   function automatic int pick_model();
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_req_i[(rr_model + i) % NUM_CH]) begin
            return (rr_model + i) % NUM_CH;
         end
      end
      return -1;
   endfunction

   task automatic set_desc(input int ch, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int size, input bit si, input bit di);
      d_src[ch]  = src;
      d_dst[ch]  = dst;
      d_len[ch]  = len;
      d_size[ch] = size;
      d_si[ch]   = si;
      d_di[ch]   = di;
      ch_src_addr_i[ch*32 +: 32]     = src;
      ch_dst_addr_i[ch*32 +: 32]     = dst;
      ch_len_i[ch*LEN_W +: LEN_W]    = LEN_W'(len);
      ch_size_i[ch*2 +: 2]           = 2'(size);
      ch_src_incr_i[ch]              = si;
      ch_dst_incr_i[ch]              = di;
   endtask

   task automatic finish_desc(input int ch, input bit drop);
      if (drop) begin
         ch_req_i[ch] = 1'b0;
      end
      rr_model = (ch + 1) % NUM_CH;
   endtask

   task automatic check_fields(input logic [31:0] s, input logic [31:0] d, input int c, input int size);
      check("rd_addr", eng_rd_addr_o, s);
      check("wr_addr", eng_wr_addr_o, d);
      check("len", 32'(eng_len_o), 32'(c));
      check("size", 32'(eng_size_o), 32'(size));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(ch_busy_o), 0);
      check({tag, "_done"}, 32'(ch_done_o), 0);
      check({tag, "_err"}, 32'(ch_err_o), 0);
      check({tag, "_valid"}, 32'(eng_valid_o), 0);
      check({tag, "_mode"}, 32'(eng_mode_o), 0);
      check({tag, "_rd_addr"}, eng_rd_addr_o, 0);
      check({tag, "_wr_addr"}, eng_wr_addr_o, 0);
      check({tag, "_len"}, 32'(eng_len_o), 0);
      check({tag, "_size"}, 32'(eng_size_o), 0);
      check({tag, "_incr"}, 32'(eng_incr_o), 0);
      check({tag, "_enable"}, 32'(eng_enable_o), 0);
      check({tag, "_race"}, 32'(eng_race_o), 0);
   endtask

   task automatic apply_reset();
      hresetn          = 1'b0;
      ch_req_i         = '0;
      eng_last_i       = 1'b0;
      eng_last_write_i = 1'b0;
      hresp_i          = 1'b0;
      eng_ready_i      = 1'b1;
      rr_model         = 0;
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
   endtask

   // Called just after a negedge with the scheduler idle and eng_ready_i high.
   // Plays the engine for the next granted descriptor; an error response is
   // injected in the write phase of chunk err_chunk (-1 for none).
   task automatic serve(input int err_chunk, input bit err_with_last, input bit drop);
      int          ch, rem, c, j, k;
      logic [31:0] s, d;
      bit          bad;
      ch = pick_model();
      if (ch < 0) begin
         $display("FAIL serve: no requesting channel at call");
         $fatal(1, "bench sequencing error");
      end
      bad = (d_len[ch] == 0) || (d_size[ch] == 3) || ((d_len[ch] % (1 << d_size[ch])) != 0);
      @(negedge hclk);
      if (bad) begin
         check("err_pulse", 32'(ch_err_o), onehot(ch));
         check("err_no_valid", 32'(eng_valid_o), 0);
         check("err_no_busy", 32'(ch_busy_o), 0);
         check("err_no_done", 32'(ch_done_o), 0);
         finish_desc(ch, drop);
         @(negedge hclk);
         check("err_then_idle", 32'(eng_enable_o), 0);
         check("err_single", 32'(ch_err_o), 0);
         return;
      end
      check("grant", 32'(ch_busy_o), onehot(ch));
      check("enable", 32'(eng_enable_o), 1);
      rem = d_len[ch];
      s   = d_src[ch];
      d   = d_dst[ch];
      j   = 0;
      while (rem > 0) begin
         c = (rem < CMAX) ? rem : CMAX;
         #1;
         check("rd_valid", 32'(eng_valid_o), 1);
         check("rd_mode", 32'(eng_mode_o), 0);
         check("rd_incr", 32'(eng_incr_o), 32'(d_si[ch]));
         check_fields(s, d, c, d_size[ch]);
         @(negedge hclk);
         eng_ready_i = 1'b0;
         k = $urandom_range(0, 2);
         repeat (k) @(negedge hclk);
         #1;
         check("rd_wait_valid", 32'(eng_valid_o), 0);
         check("rd_wait_busy", 32'(ch_busy_o), onehot(ch));
         check_fields(s, d, c, d_size[ch]);
         eng_last_i = 1'b1;
         @(negedge hclk);
         eng_last_i = 1'b0;
         @(negedge hclk);
         eng_ready_i = 1'b1;
         #1;
         check("wr_valid", 32'(eng_valid_o), 1);
         check("wr_mode", 32'(eng_mode_o), 1);
         check("wr_incr", 32'(eng_incr_o), 32'(d_di[ch]));
         check_fields(s, d, c, d_size[ch]);
         @(negedge hclk);
         eng_ready_i = 1'b0;
         eng_last_i  = 1'b1;
         @(negedge hclk);
         eng_last_i = 1'b0;
         check("wr_wait_no_done", 32'(ch_done_o), 0);
         check("wr_wait_busy", 32'(ch_busy_o), onehot(ch));
         k = $urandom_range(0, 2);
         repeat (k) @(negedge hclk);
         check_fields(s, d, c, d_size[ch]);
         if (j == err_chunk) begin
            hresp_i          = 1'b1;
            eng_last_write_i = err_with_last;
            @(negedge hclk);
            hresp_i          = 1'b0;
            eng_last_write_i = 1'b0;
            check("hresp_err", 32'(ch_err_o), onehot(ch));
            check("hresp_no_done", 32'(ch_done_o), 0);
            check("hresp_busy_drop", 32'(ch_busy_o), 0);
            finish_desc(ch, drop);
            eng_ready_i = 1'b1;
            @(negedge hclk);
            check("hresp_idle", 32'(eng_enable_o), 0);
            check("hresp_err_single", 32'(ch_err_o), 0);
            return;
         end
         eng_last_write_i = 1'b1;
         @(negedge hclk);
         eng_last_write_i = 1'b0;
         rem -= c;
         if (d_si[ch]) s += 32'(c);
         if (d_di[ch]) d += 32'(c);
         j++;
         if (rem == 0) begin
            check("done", 32'(ch_done_o), onehot(ch));
            check("done_busy_drop", 32'(ch_busy_o), 0);
            check("done_no_err", 32'(ch_err_o), 0);
            finish_desc(ch, drop);
            eng_ready_i = 1'b1;
            @(negedge hclk);
            check("done_single", 32'(ch_done_o), 0);
            check("done_idle", 32'(eng_enable_o), 0);
         end else begin
            check("chunk_busy", 32'(ch_busy_o), onehot(ch));
            check("chunk_no_done", 32'(ch_done_o), 0);
            @(negedge hclk);
            eng_ready_i = 1'b1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      hresetn          = 1'b0;
      ch_req_i         = '0;
      ch_src_addr_i    = '0;
      ch_dst_addr_i    = '0;
      ch_len_i         = '0;
      ch_size_i        = '0;
      ch_src_incr_i    = '0;
      ch_dst_incr_i    = '0;
      eng_ready_i      = 1'b1;
      eng_last_i       = 1'b0;
      eng_last_write_i = 1'b0;
      hresp_i          = 1'b0;
      rr_model         = 0;
      repeat (2) @(negedge hclk);
      check_all_zero("rst");
      hresetn = 1'b1;
      @(negedge hclk);
      check_all_zero("idle");

      // Single-chunk word transfer.
      set_desc(0, 32'h100, 32'h200, 16, 2, 1'b1, 1'b1);
      ch_req_i[0] = 1'b1;
      serve(-1, 1'b0, 1'b1);

      // Three chunks: 16/16/8.
      set_desc(1, 32'h100, 32'h300, 40, 2, 1'b1, 1'b1);
      ch_req_i[1] = 1'b1;
      serve(-1, 1'b0, 1'b1);

      // Round-robin from reset with ch0 re-requesting: ch0, ch2, ch0.
      apply_reset();
      set_desc(0, 32'h400, 32'h500, 8, 1, 1'b1, 1'b1);
      set_desc(2, 32'h600, 32'h700, 20, 2, 1'b1, 1'b1);
      ch_req_i = 4'b0101;
      serve(-1, 1'b0, 1'b0);
      serve(-1, 1'b0, 1'b1);
      serve(-1, 1'b0, 1'b1);

      // Illegal descriptors: misaligned length, zero length, size 3.
      set_desc(3, 32'h800, 32'h900, 6, 2, 1'b1, 1'b1);
      ch_req_i[3] = 1'b1;
      serve(-1, 1'b0, 1'b1);
      set_desc(3, 32'h800, 32'h900, 0, 0, 1'b1, 1'b1);
      ch_req_i[3] = 1'b1;
      serve(-1, 1'b0, 1'b1);
      set_desc(1, 32'h800, 32'h900, 8, 3, 1'b1, 1'b1);
      ch_req_i[1] = 1'b1;
      serve(-1, 1'b0, 1'b1);

      // Error response in chunk 2 write phase, coinciding with the last-write pulse.
      set_desc(1, 32'hA00, 32'hB00, 40, 2, 1'b1, 1'b1);
      ch_req_i[1] = 1'b1;
      serve(1, 1'b1, 1'b1);

      // Fixed destination, byte beats.
      set_desc(2, 32'h1000, 32'h2000, 32, 0, 1'b1, 1'b0);
      ch_req_i[2] = 1'b1;
      serve(-1, 1'b0, 1'b1);

      // Address wrap at 2^32.
      set_desc(0, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32, 2, 1'b1, 1'b1);
      ch_req_i[0] = 1'b1;
      serve(-1, 1'b0, 1'b1);

      // Randomized descriptors and request mixes.
      for (int it = 0; it < 12; it++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            int len, size;
            size = $urandom_range(0, 3);
            len  = $urandom_range(0, 70);
            if (($urandom_range(0, 3) != 0) && (size < 3)) begin
               len = len & ~((1 << size) - 1);
            end
            set_desc(ch, $urandom, $urandom, len, size, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
         end
         ch_req_i = 4'($urandom_range(1, 15));
         while (ch_req_i != '0) begin
            serve(($urandom_range(0, 5) == 0) ? 0 : -1, 1'($urandom_range(0, 1)), 1'b1);
         end
      end

      // Reset in the middle of a transfer; the round-robin pointer must restart at 0.
      set_desc(2, 32'h40, 32'h80, 16, 2, 1'b1, 1'b1);
      ch_req_i = 4'b0100;
      serve(-1, 1'b0, 1'b1);
      set_desc(3, 32'hC0, 32'hE0, 32, 2, 1'b1, 1'b1);
      set_desc(0, 32'h20, 32'h60, 12, 2, 1'b1, 1'b1);
      ch_req_i = 4'b1000;
      @(negedge hclk);
      check("mid_grant", 32'(ch_busy_o), onehot(3));
      @(negedge hclk);
      eng_ready_i = 1'b0;
      hresetn     = 1'b0;
      #1;
      check_all_zero("mid_rst");
      ch_req_i = 4'b1001;
      @(negedge hclk);
      check("mid_rst_no_done", 32'(ch_done_o), 0);
      check("mid_rst_no_err", 32'(ch_err_o), 0);
      hresetn     = 1'b1;
      eng_ready_i = 1'b1;
      rr_model    = 0;
      serve(-1, 1'b0, 1'b1);
      serve(-1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
